zone_cmd_sequencer: RTL

//  Command-side partner of the two-zone valve/water controller: generates the G1/G2 zone request codes it consumes.

---
 rtl/zone_pkg.sv | 35 +++
 rtl/zone_cmd_sequencer_tick_gen.sv | 33 +++
 rtl/zone_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/zone_pkg.sv
// -----------------------------------------------------------------------------
// zone_pkg
// Types and codes shared by the two-zone valve/water controller and its command
// sequencer: zone request codes, the controller error code, sequencer states,
// and a helper that decides whether a programmed phase has anything to do.
// -----------------------------------------------------------------------------
package zone_pkg;

  // Zone request codes driven on G1/G2.
  typedef enum logic [1:0] {
    CMD_STOP = 2'b00,
    CMD_A    = 2'b01,
    CMD_B    = 2'b10,
    CMD_AGUA = 2'b11
  } cmd_t;

  // Controller error code on E. Any value other than ERR_CODE means no error.
  localparam logic [1:0] ERR_CODE = 2'b11;
  localparam logic [1:0] NO_ERR   = 2'b00;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RUN1,
    SEQ_RUN2,
    SEQ_PAUSE,
    SEQ_DONE,
    SEQ_FAULT
  } seq_state_t;

  // A phase with mode STOP or zero duration is skipped entirely.
  function automatic logic phase_empty(cmd_t mode, logic dur_is_zero);
    return (mode == CMD_STOP) || dur_is_zero;
  endfunction

endpackage

// File: rtl/zone_cmd_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// With TICK_DIV=1 the tick is high on every cycle.
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   tick_o out  one-cycle tick pulse
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
  assign tick_o = (cnt_q == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/zone_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// zone_cmd_sequencer
// Runs a programmed two-phase cycle (zone 1 in mode m1 for d1 ticks, then
// zone 2 in mode m2 for d2 ticks), producing the G1/G2 zone request codes.
// Controller errors (E==11) pause the cycle, retry after RETRY_WAIT ticks and
// latch FAULT once more than MAX_RETRY errors occur within one cycle.
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   latch program and begin cycle (IDLE only)
//   stop        in   abort cycle back to IDLE (ignored in FAULT)
//   clear       in   leave FAULT
//   m1, m2      in   zone mode codes
//   d1, d2      in   phase durations in ticks
//   E           in   controller error code
//   G1, G2      out  registered zone request codes
//   busy        out  high in RUN1/RUN2/PAUSE
//   done        out  one-cycle pulse on normal completion
//   fault       out  high while in FAULT
// -----------------------------------------------------------------------------
module zone_cmd_sequencer
  import zone_pkg::*;
#(
  parameter int unsigned DUR_W      = 8,
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned RETRY_WAIT = 4,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  input  logic [DUR_W-1:0] d1,
  input  logic [DUR_W-1:0] d2,
  input  logic [1:0]       E,
  output logic [1:0]       G1,
  output logic [1:0]       G2,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int unsigned       WAIT_W      = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(RETRY_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
  localparam int unsigned       RETRY_W     = $clog2(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
  localparam logic [DUR_W-1:0]  REM_ONE     = DUR_W'(1);

  seq_state_t         state_q, state_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               in_p2_q, in_p2_d;   // saved phase: 0 = zone 1, 1 = zone 2
  cmd_t               m1_q, m1_d, m2_q, m2_d;
  logic [DUR_W-1:0]   d2_q, d2_d;
  cmd_t               g1_q, g1_d, g2_q, g2_d;
  logic               busy_q, busy_d, done_q, done_d, fault_q, fault_d;

  logic tick;
  logic err;
  logic p2_empty;
  logic retry_full;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (reset),
    .tick_o (tick)
  );

  assign err        = (E == ERR_CODE);
  assign p2_empty   = phase_empty(m2_q, d2_q == '0);
  // Another error now would exceed the tolerated count.
  assign retry_full = (retry_q == RETRY_LIMIT);

  // NOTE: every variable driven here receives a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    retry_d = retry_q;
    in_p2_d = in_p2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    d2_d    = d2_q;

    case (state_q)
      SEQ_IDLE: begin
        if (start && !stop) begin
          m1_d    = cmd_t'(m1);
          m2_d    = cmd_t'(m2);
          d2_d    = d2;
          retry_d = '0;
          if (!phase_empty(cmd_t'(m1), d1 == '0)) begin
            state_d = SEQ_RUN1;
            rem_d   = d1;
            in_p2_d = 1'b0;
          end else if (!phase_empty(cmd_t'(m2), d2 == '0)) begin
            state_d = SEQ_RUN2;
            rem_d   = d2;
            in_p2_d = 1'b1;
          end else begin
            state_d = SEQ_DONE;
          end
        end
      end

      SEQ_RUN1, SEQ_RUN2: begin
        if (stop) begin
          state_d = SEQ_IDLE;
        end else begin
          // The active cycle in which an error is seen still consumes its
          // tick, so an error on the expiry tick pauses with remaining = 0.
          if (tick) rem_d = rem_q - REM_ONE;
          if (err) begin
            in_p2_d = (state_q == SEQ_RUN2);
            wait_d  = '0;
            retry_d = retry_q + RETRY_ONE;
            state_d = retry_full ? SEQ_FAULT : SEQ_PAUSE;
          end else if (tick && rem_q == REM_ONE) begin
            if (state_q == SEQ_RUN1 && !p2_empty) begin
              state_d = SEQ_RUN2;
              rem_d   = d2_q;
              in_p2_d = 1'b1;
            end else begin
              state_d = SEQ_DONE;
            end
          end
        end
      end

      SEQ_PAUSE: begin
        if (stop) begin
          state_d = SEQ_IDLE;
        end else if (tick) begin
          if (wait_q != WAIT_LAST) begin
            wait_d = wait_q + WAIT_ONE;
          end else if (err) begin
            // Still failing at the end of the wait: a fresh error entry.
            wait_d  = '0;
            retry_d = retry_q + RETRY_ONE;
            state_d = retry_full ? SEQ_FAULT : SEQ_PAUSE;
          end else if (rem_q != '0) begin
            state_d = in_p2_q ? SEQ_RUN2 : SEQ_RUN1;
          end else if (!in_p2_q && !p2_empty) begin
            state_d = SEQ_RUN2;
            rem_d   = d2_q;
            in_p2_d = 1'b1;
          end else begin
            state_d = SEQ_DONE;
          end
        end
      end

      SEQ_DONE: begin
        state_d = SEQ_IDLE;
        retry_d = '0;
      end

      SEQ_FAULT: begin
        if (clear) begin
          state_d = SEQ_IDLE;
          retry_d = '0;
        end
      end

      default: state_d = SEQ_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // that enters the state.
  always_comb begin
    g1_d    = (state_d == SEQ_RUN1) ? m1_d : CMD_STOP;
    g2_d    = (state_d == SEQ_RUN2) ? m2_d : CMD_STOP;
    busy_d  = (state_d == SEQ_RUN1) || (state_d == SEQ_RUN2) || (state_d == SEQ_PAUSE);
    done_d  = (state_d == SEQ_DONE);
    fault_d = (state_d == SEQ_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEQ_IDLE;
      rem_q   <= '0;
      wait_q  <= '0;
      retry_q <= '0;
      in_p2_q <= 1'b0;
      m1_q    <= CMD_STOP;
      m2_q    <= CMD_STOP;
      d2_q    <= '0;
      g1_q    <= CMD_STOP;
      g2_q    <= CMD_STOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      in_p2_q <= in_p2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      d2_q    <= d2_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign G1    = g1_q;
  assign G2    = g2_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign fault = fault_q;

endmodule
